// File: rtl/mips_inst_encoder.sv
// Sequential MIPS64r6 instruction encoder: field requests in, addressed 32-bit words out.
// Define ENCODER_PSEUDO_EN to build LI (LUI+ORI) expansion and the EMIT1 state.
module mips_inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [5:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_sa,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [15:0]       count
);

    localparam logic [5:0] OP_OTHER0      = 6'h00;
    localparam logic [5:0] OP_SPECIAL3    = 6'h1F;
    localparam logic [5:0] OP3_FUNC_BSHFL = 6'h20;
    localparam logic [5:0] OP_LUI         = 6'h0F;
    localparam logic [5:0] OP_ORI         = 6'h0D;

    localparam logic [2:0] KIND_R     = 3'd0;
    localparam logic [2:0] KIND_I     = 3'd1;
    localparam logic [2:0] KIND_J     = 3'd2;
    localparam logic [2:0] KIND_SHIFT = 3'd3;
    localparam logic [2:0] KIND_LI    = 3'd4;
    localparam logic [2:0] KIND_BSHFL = 3'd5;

    // state | meaning
    // IDLE  | no word held, ready for a request
    // EMIT0 | first (or only) word of a request on out_word
    // EMIT1 | second LI word (ORI) on out_word
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT0 = 2'd1
`ifdef ENCODER_PSEUDO_EN
        , EMIT1 = 2'd2
`endif
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        req_fire;
    logic        out_fire;
    logic        load_new;
    logic        enc_legal;
    logic [31:0] enc_w0;

`ifdef ENCODER_PSEUDO_EN
    logic        enc_two;
    logic [31:0] enc_w1;
    logic        load_second;
    logic        two_word;
    logic [31:0] word1;
`else
    logic        unused_imm;
    assign unused_imm = &{1'b0, req_imm[31:26]};
`endif

    always_comb begin
        enc_legal = 1'b1;
        enc_w0    = '0;
`ifdef ENCODER_PSEUDO_EN
        enc_two   = 1'b0;
        enc_w1    = '0;
`endif
        case (req_kind)
            KIND_R:     enc_w0 = {OP_OTHER0, req_rs, req_rt, req_rd, 5'd0, req_op};
            KIND_I:     enc_w0 = {req_op, req_rs, req_rt, req_imm[15:0]};
            KIND_J:     enc_w0 = {req_op, req_imm[25:0]};
            KIND_SHIFT: enc_w0 = {OP_OTHER0, 5'd0, req_rt, req_rd, req_sa, req_op};
            KIND_BSHFL: enc_w0 = {OP_SPECIAL3, 5'd0, req_rt, req_rd, req_op[4:0], OP3_FUNC_BSHFL};
`ifdef ENCODER_PSEUDO_EN
            KIND_LI: begin
                // A zero upper half fits in one ORI from $zero.
                if (req_imm[31:16] != 16'd0) begin
                    enc_two = 1'b1;
                    enc_w0  = {OP_LUI, 5'd0, req_rt, req_imm[31:16]};
                    enc_w1  = {OP_ORI, req_rt, req_rt, req_imm[15:0]};
                end else begin
                    enc_w0  = {OP_ORI, 5'd0, req_rt, req_imm[15:0]};
                end
            end
`endif
            default:    enc_legal = 1'b0;
        endcase
    end

    assign out_valid = reset && (state != IDLE);
    assign out_fire  = out_valid && out_ready;
    assign req_fire  = req_valid && req_ready;

`ifdef ENCODER_PSEUDO_EN
    assign req_ready = reset && !flush &&
                       ((state == IDLE) ||
                        ((state == EMIT0) && out_ready && !two_word) ||
                        ((state == EMIT1) && out_ready));
`else
    assign req_ready = reset && !flush &&
                       ((state == IDLE) || ((state == EMIT0) && out_ready));
`endif

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_new    = 1'b0;
`ifdef ENCODER_PSEUDO_EN
        load_second = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_fire && enc_legal) begin
                    state_next = EMIT0;
                    load_new   = 1'b1;
                end
            end
            EMIT0: begin
                if (out_fire) begin
`ifdef ENCODER_PSEUDO_EN
                    if (two_word) begin
                        state_next  = EMIT1;
                        load_second = 1'b1;
                    end else
`endif
                    if (req_fire && enc_legal) begin
                        state_next = EMIT0;
                        load_new   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
`ifdef ENCODER_PSEUDO_EN
            EMIT1: begin
                if (out_fire) begin
                    if (req_fire && enc_legal) begin
                        state_next = EMIT0;
                        load_new   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_word <= '0;
            out_addr <= BASE_ADDR;
            count    <= '0;
            err      <= 1'b0;
`ifdef ENCODER_PSEUDO_EN
            two_word <= 1'b0;
            word1    <= '0;
`endif
        end else if (flush) begin
            out_addr <= BASE_ADDR;
            count    <= '0;
            err      <= 1'b0;
`ifdef ENCODER_PSEUDO_EN
            two_word <= 1'b0;
`endif
        end else begin
            // Illegal kinds are still accepted so the producer is never stalled by them.
            err <= req_fire && !enc_legal;
            if (out_fire) begin
                out_addr <= out_addr + ADDR_W'(4);
                count    <= count + 16'd1;
            end
            if (load_new) begin
                out_word <= enc_w0;
`ifdef ENCODER_PSEUDO_EN
                word1    <= enc_w1;
                two_word <= enc_two;
            end else if (load_second) begin
                out_word <= word1;
                two_word <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Self-checking bench for mips_inst_encoder: directed vectors, LI/flush/reset sequences, random traffic
// against a queue-based model of the emitted word stream. Adapts to ENCODER_PSEUDO_EN.
module tb_mips_inst_encoder;

    logic        clock = 1'b0;
    logic        reset, flush, req_valid, out_ready;
    logic        req_ready, out_valid, err;
    logic [2:0]  req_kind;
    logic [5:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd, req_sa;
    logic [31:0] req_imm, out_word, out_addr;
    logic [15:0] count;

    always #5 clock = ~clock;

    mips_inst_encoder dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_sa(req_sa), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .err(err), .count(count)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_addr;
    logic [15:0] m_count;
    logic        m_err;
    logic        last_req_fire;

    typedef struct {
        logic [2:0]  kind;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sa;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word = sum of fields placed at their bit positions.
    function automatic void model_enc(input logic [2:0] k, input logic [5:0] op,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sa,
                                      input logic [31:0] imm, output bit legal,
                                      output int n, output logic [31:0] w0,
                                      output logic [31:0] w1);
        legal = 1'b1; n = 1; w0 = 0; w1 = 0;
        case (k)
            3'd0: w0 = (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + 32'(op);
            3'd1: w0 = (32'(op) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + (imm % 32'h10000);
            3'd2: w0 = (32'(op) << 26) + (imm % 32'h0400_0000);
            3'd3: w0 = (32'(rt) << 16) + (32'(rd) << 11) + (32'(sa) << 6) + 32'(op);
            3'd5: w0 = (32'd31 << 26) + (32'(rt) << 16) + (32'(rd) << 11)
                       + ((32'(op) % 32) << 6) + 32'd32;
`ifdef ENCODER_PSEUDO_EN
            3'd4: begin
                if (imm >= 32'h10000) begin
                    n  = 2;
                    w0 = (32'd15 << 26) + (32'(rt) << 16) + (imm / 32'h10000);
                    w1 = (32'd13 << 26) + (32'(rt) << 21) + (32'(rt) << 16) + (imm % 32'h10000);
                end else begin
                    w0 = (32'd13 << 26) + (32'(rt) << 16) + imm;
                end
            end
`endif
            default: legal = 1'b0;
        endcase
    endfunction

    // One clock: check outputs at negedge, advance the model at posedge, return at posedge+1.
    task automatic step();
        bit          rf, of, legal, m_ready, m_valid;
        int          n;
        logic [31:0] w0, w1;
        @(negedge clock);
        m_valid = reset && (exp_q.size() != 0);
        m_ready = reset && !flush && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("err", 32'(err), 32'(m_err));
        chk("count", 32'(count), 32'(m_count));
        if (m_valid) begin
            chk("out_word", out_word, exp_q[0]);
            chk("out_addr", out_addr, m_addr);
        end
        rf = req_valid && m_ready;
        of = m_valid && out_ready;
        model_enc(req_kind, req_op, req_rs, req_rt, req_rd, req_sa, req_imm, legal, n, w0, w1);
        @(posedge clock);
        if (!reset || flush) begin
            exp_q.delete();
            m_addr = 0; m_count = 0; m_err = 1'b0;
        end else begin
            m_err = rf && !legal;
            if (of) begin
                void'(exp_q.pop_front());
                m_addr  = m_addr + 4;
                m_count = m_count + 16'd1;
            end
            if (rf && legal) begin
                exp_q.push_back(w0);
                if (n == 2) exp_q.push_back(w1);
            end
        end
        last_req_fire = rf;
        #1;
    endtask

    task automatic set_req(input logic [2:0] k, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sa,
                           input logic [31:0] imm);
        req_kind = k; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_sa = sa;
        req_imm = imm;
    endtask

    task automatic send(input logic [2:0] k, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sa,
                        input logic [31:0] imm);
        bit done = 1'b0;
        set_req(k, op, rs, rt, rd, sa, imm);
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = last_req_fire;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        set_req(3'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        m_addr = 0; m_count = 0; m_err = 1'b0; last_req_fire = 1'b0;

        tbl[0] = '{3'd1, 6'h09, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_1234, 32'h2408_1234};
        tbl[1] = '{3'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0100, 32'h0800_0100};
        tbl[2] = '{3'd5, 6'h10, 5'd0, 5'd4, 5'd5, 5'd0, 32'h0, 32'h7C04_2C20};
        tbl[3] = '{3'd3, 6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 32'h0, 32'h0002_1900};
`ifdef ENCODER_PSEUDO_EN
        tbl[4] = '{3'd4, 6'h00, 5'd0, 5'd9, 5'd0, 5'd0, 32'h0000_0042, 32'h3409_0042};
`else
        tbl[4] = '{3'd0, 6'h23, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0, 32'h0085_3023};
`endif

        repeat (2) @(posedge clock);
        #1;
        step();
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        reset = 1'b1;
        step();

        // ADDU straight after reset
        send(3'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        chk("addu_word", out_word, 32'h0022_1821);
        chk("addu_addr", out_addr, 32'd0);
        step();
        chk("addu_count", 32'(count), 32'd1);

        // back-to-back table, one word per cycle
        do_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(tbl[i].kind, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sa, tbl[i].imm);
            req_valid = 1'b1;
            step();
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_word", out_word, tbl[i].exp);
            chk("tbl_addr", out_addr, 32'(4 * i));
        end
        req_valid = 1'b0;
        step();
        chk("tbl_count", 32'(count), 32'd5);

`ifdef ENCODER_PSEUDO_EN
        // LI two-word with backpressure on the first word
        do_flush();
        out_ready = 1'b0;
        send(3'd4, 6'd0, 5'd0, 5'd9, 5'd0, 5'd0, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            chk("li_hold_word", out_word, 32'h3C09_1234);
            chk("li_hold_addr", out_addr, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("li_word1", out_word, 32'h3529_5678);
        chk("li_addr1", out_addr, 32'd4);
        step();
        chk("li_count", 32'(count), 32'd2);

        // flush while second LI word is pending
        send(3'd4, 6'd0, 5'd0, 5'd3, 5'd0, 5'd0, 32'hABCD_0001);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        send(3'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        chk("flush_next_addr", out_addr, 32'd0);
        chk("flush_next_word", out_word, 32'h0022_1821);
        step();

        // reset while second LI word is pending
        send(3'd4, 6'd0, 5'd0, 5'd7, 5'd0, 5'd0, 32'h0001_0000);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rstli_valid", 32'(out_valid), 32'd0);
        chk("rstli_count", 32'(count), 32'd0);
        step();
`else
        // LI is illegal in this build
        do_flush();
        send(3'd4, 6'd0, 5'd0, 5'd9, 5'd0, 5'd0, 32'h1234_5678);
        chk("li_err", 32'(err), 32'd1);
        chk("li_no_word", 32'(out_valid), 32'd0);
        step();
        chk("li_err_clear", 32'(err), 32'd0);
`endif

        // illegal kind 7
        send(3'd7, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 32'hFFFF_FFFF);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        chk("ill_count", 32'(count), 32'(m_count));
        step();
        chk("ill_err_clear", 32'(err), 32'd0);
        send(3'd1, 6'h09, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_1234);
        chk("ill_next_word", out_word, 32'h2408_1234);
        step();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            set_req(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 65535)) : $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
